// File: rtl/cdc_tx_arbiter.sv
// cdc_tx_arbiter: round-robin arbiter feeding a four-phase CDC request channel.
//
// A grant captures one requester's payload into data_i and raises valid_i. The
// transfer then completes as the acknowledge (valid_o, already synchronized into
// clk_send) rises and falls. Only one transfer is in flight at a time.
//
// Ports:
//   clk_send    in   sole clock, rising edge
//   resetn_send in   asynchronous active-low reset
//   req_i       in   per-requester level request (payload stable while high)
//   req_data_i  in   packed payloads, requester k at [k*DATA_W +: DATA_W]
//   gnt_o       out  one-hot, one-cycle pulse when a payload is captured
//   data_i      out  payload towards the CDC channel
//   valid_i     out  CDC request level
//   valid_o     in   CDC acknowledge level
//   busy_o      out  high whenever a transfer is in progress
//   err_o       out  sticky handshake-timeout flag
//
// Optional feature: define CDC_TX_ARBITER_TIMEOUT_EN to build a 16-bit
// watchdog that abandons a stalled handshake phase after TIMEOUT cycles.
// Without it, err_o is tied low and each ack edge is awaited indefinitely.

module cdc_tx_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    clk_send,
    input  logic                    resetn_send,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*DATA_W-1:0] req_data_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [DATA_W-1:0]       data_i,
    output logic                    valid_i,
    input  logic                    valid_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned PtrW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : gen_param_check
        $fatal(1, "cdc_tx_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSend    = 2'd1,
        StRelease = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic              sel_found;
    logic [PtrW-1:0]   sel_idx;
    logic [N_REQ-1:0]  sel_onehot;
    logic [DATA_W-1:0] sel_data;
    logic              grant;
    logic              send_to;
    logic              rel_to;

    // Round-robin pick: first pass covers [rr_ptr, N_REQ), second pass wraps to [0, rr_ptr).
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!sel_found && req_i[j] && (PtrW'(j) >= rr_ptr_q)) begin
                sel_found = 1'b1;
                sel_idx   = PtrW'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!sel_found && req_i[j]) begin
                sel_found = 1'b1;
                sel_idx   = PtrW'(j);
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        sel_data   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (sel_found && (sel_idx == PtrW'(j))) begin
                sel_onehot[j] = 1'b1;
                sel_data      = req_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

    // A still-high ack in IDLE is stale (e.g. across reset): wait for it to fall.
    assign grant = (state_q == StIdle) && !valid_o && sel_found;

`ifdef CDC_TX_ARBITER_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    logic [15:0] timer_q, timer_d;
    logic        err_q, err_d;

    // Timer counts cycles spent in the current phase; firing on TimeoutLast means
    // the phase lasted exactly TIMEOUT cycles. A genuine ack takes precedence.
    assign send_to = (state_q == StSend) && (timer_q == TimeoutLast);
    assign rel_to  = (state_q == StRelease) && (timer_q == TimeoutLast);

    always_comb begin
        timer_d = timer_q + 16'd1;
        if ((state_d != state_q) || (state_q == StIdle)) begin
            timer_d = '0;
        end
        err_d = err_q | (send_to && !valid_o) | (rel_to && valid_o);
    end

    always_ff @(posedge clk_send or negedge resetn_send) begin
        if (!resetn_send) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign send_to = 1'b0;
    assign rel_to  = 1'b0;
    assign err_o   = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk_send or negedge resetn_send) begin
        if (!resetn_send) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (grant) state_d = StSend;
            StSend:    if (valid_o || send_to) state_d = StRelease;
            StRelease: if (!valid_o || rel_to) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        gnt_d    = '0;
        data_d   = data_q;
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        if (grant) begin
            gnt_d    = sel_onehot;
            data_d   = sel_data;
            valid_d  = 1'b1;
            rr_ptr_d = (sel_idx == PtrW'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
        if ((state_q == StSend) && (state_d == StRelease)) begin
            valid_d = 1'b0;
        end
    end

    assign gnt_o   = gnt_q;
    assign data_i  = data_q;
    assign valid_i = valid_q;
    assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Self-checking bench for cdc_tx_arbiter (N_REQ=4, DATA_W=8, TIMEOUT=16).
// A table of request patterns with hand-derived grant indices drives the main
// round-robin checks; expected grants go into a scoreboard queue that a monitor
// pops whenever gnt_o pulses. Hand-written sequences cover late requesters,
// handshake timeout, stale ack after reset and reset in mid-transfer.

module tb_cdc_tx_arbiter;

    logic        clk_send;
    logic        resetn_send;
    logic [3:0]  req_i;
    logic [31:0] req_data_i;
    logic [3:0]  gnt_o;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        valid_o;
    logic        busy_o;
    logic        err_o;

    cdc_tx_arbiter #(
        .N_REQ  (4),
        .DATA_W (8),
        .TIMEOUT(16)
    ) dut (
        .clk_send   (clk_send),
        .resetn_send(resetn_send),
        .req_i      (req_i),
        .req_data_i (req_data_i),
        .gnt_o      (gnt_o),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    initial clk_send = 1'b0;
    always #5 clk_send = ~clk_send;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] pl;
        int          idx;
    } row_t;

    row_t rows[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int idx, input logic [31:0] pl);
        exp_t e;
        e.gnt  = 4'(1 << idx);
        e.data = 8'(pl >> (8 * idx));
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every grant pulse must match the oldest expectation.
    always @(negedge clk_send) begin
        if (gnt_o != 4'b0000) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_grant: got gnt_o=%b, expected no grant", gnt_o);
            end else begin
                mon_e = sb_q.pop_front();
                check("gnt_o", 32'(gnt_o), 32'(mon_e.gnt));
                check("data_i_at_gnt", 32'(data_i), 32'(mon_e.data));
                check("valid_i_at_gnt", 32'(valid_i), 32'd1);
            end
        end
    end

    // Grant is expected on the first posedge after the request is presented.
    task automatic wait_grant(input string name);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk_send);
            lat++;
            if (gnt_o != 4'b0000) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no grant in 20 cycles, expected a grant", name);
        end else begin
            check({name, "_latency"}, 32'(lat), 32'd1);
        end
    endtask

    // Called on the negedge where the grant is visible; finishes the four-phase
    // handshake and returns on the negedge where the FSM is back in IDLE.
    task automatic handshake(input int hold, input logic [7:0] d);
        repeat (hold) begin
            @(negedge clk_send);
            check("gnt_pulse", 32'(gnt_o), 32'd0);
            check("valid_hold", 32'(valid_i), 32'd1);
            check("data_hold", 32'(data_i), 32'(d));
            check("busy_send", 32'(busy_o), 32'd1);
        end
        valid_o = 1'b1;
        @(negedge clk_send);
        check("valid_drop", 32'(valid_i), 32'd0);
        check("busy_release", 32'(busy_o), 32'd1);
        valid_o = 1'b0;
        @(negedge clk_send);
        check("busy_idle", 32'(busy_o), 32'd0);
        check("valid_idle", 32'(valid_i), 32'd0);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_valid_i"}, 32'(valid_i), 32'd0);
        check({name, "_data_i"}, 32'(data_i), 32'd0);
        check({name, "_gnt_o"}, 32'(gnt_o), 32'd0);
        check({name, "_busy_o"}, 32'(busy_o), 32'd0);
        check({name, "_err_o"}, 32'(err_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // Grant order hand-derived from the rotating pointer (starts at 0).
        rows[0]  = '{4'b1111, 32'h44332211, 0};
        rows[1]  = '{4'b1111, 32'h88776655, 1};
        rows[2]  = '{4'b1111, 32'hccbbaa99, 2};
        rows[3]  = '{4'b1111, 32'h01f0eedd, 3};
        rows[4]  = '{4'b1111, 32'h5a6b7c8d, 0};
        rows[5]  = '{4'b1111, 32'h12345678, 1};
        rows[6]  = '{4'b1111, 32'h9abcdef0, 2};
        rows[7]  = '{4'b1111, 32'h0f1e2d3c, 3};
        rows[8]  = '{4'b0100, 32'h00a50000, 2};
        rows[9]  = '{4'b0011, 32'h0000c3b4, 0};
        rows[10] = '{4'b0011, 32'h0000e7d6, 1};
        rows[11] = '{4'b1000, 32'h7f000000, 3};
        rows[12] = '{4'b1010, 32'h11002200, 1};
        rows[13] = '{4'b1010, 32'h33004400, 3};

        resetn_send = 1'b0;
        valid_o     = 1'b0;
        req_i       = 4'b0000;
        req_data_i  = 32'h0;
        #1;
        check_reset_outputs("reset");
        repeat (3) @(negedge clk_send);
        resetn_send = 1'b1;
        @(negedge clk_send);

        for (int r = 0; r < 14; r++) begin
            req_data_i = rows[r].pl;
            req_i      = rows[r].req;
            push_exp(rows[r].idx, rows[r].pl);
            wait_grant($sformatf("row%0d", r));
            handshake((r == 8) ? 3 : 1, 8'(rows[r].pl >> (8 * rows[r].idx)));
        end

        // Late requester: pointer is 0; requester 3 arrives while 0 is in SEND.
        req_data_i = 32'hd3000007;
        req_i      = 4'b0001;
        push_exp(0, req_data_i);
        wait_grant("late_first");
        req_i = 4'b1001;
        push_exp(3, req_data_i);
        push_exp(0, req_data_i);
        handshake(1, 8'h07);
        wait_grant("late_second");
        handshake(1, 8'hd3);
        wait_grant("late_third");
        req_i = 4'b0000;
        handshake(1, 8'h07);

        // Handshake timeout: ack never rises (pointer is 1, wraps to 0).
        req_data_i = 32'h000000c9;
        req_i      = 4'b0001;
        push_exp(0, req_data_i);
        wait_grant("timeout_grant");
        req_i = 4'b0000;
`ifdef CDC_TX_ARBITER_TIMEOUT_EN
        cnt = 1;
        repeat (100) begin
            @(negedge clk_send);
            if (!valid_i) break;
            cnt++;
        end
        check("timeout_cycles", 32'(cnt), 32'd16);
        check("timeout_err", 32'(err_o), 32'd1);
        check("timeout_busy_release", 32'(busy_o), 32'd1);
        @(negedge clk_send);
        check("timeout_busy_idle", 32'(busy_o), 32'd0);
        repeat (3) @(negedge clk_send);
        check("timeout_err_sticky", 32'(err_o), 32'd1);
`else
        cnt = 0;
        repeat (40) begin
            @(negedge clk_send);
            if (valid_i) cnt++;
        end
        check("no_timeout_valid_cycles", 32'(cnt), 32'd40);
        check("no_timeout_err", 32'(err_o), 32'd0);
        check("no_timeout_busy", 32'(busy_o), 32'd1);
        handshake(0, 8'hc9);
`endif

        // Stale ack held high across reset release.
        @(negedge clk_send);
        valid_o     = 1'b1;
        resetn_send = 1'b0;
        #1;
        check_reset_outputs("stale_reset");
        @(negedge clk_send);
        req_data_i  = 32'h00005e00;
        req_i       = 4'b0010;
        resetn_send = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk_send);
            if (busy_o) cnt++;
        end
        check("stale_no_busy", 32'(cnt), 32'd0);
        push_exp(1, req_data_i);
        valid_o = 1'b0;
        wait_grant("stale_grant");
        req_i = 4'b0000;
        handshake(1, 8'h5e);

        // Reset during SEND; pointer must restart at 0 (otherwise 3 would win).
        req_data_i = 32'h00a50000;
        req_i      = 4'b0100;
        push_exp(2, req_data_i);
        wait_grant("midrst_grant");
        @(negedge clk_send);
        req_i       = 4'b0000;
        resetn_send = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk_send);
        req_data_i  = 32'h66007700;
        req_i       = 4'b1010;
        push_exp(1, req_data_i);
        resetn_send = 1'b1;
        wait_grant("midrst_after");
        req_i = 4'b0000;
        handshake(1, 8'h77);

        repeat (3) @(negedge clk_send);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cdc_tx_arbiter.md
CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, payload width, matching the CDC channel data width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles to wait for each ack edge (1..65535).
REQ-004 SHALL have port clk_send  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port resetn_send  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_i  in  N_REQ  per-requester level request; payload must be stable while high.
REQ-007 SHALL have port req_data_i  in  N_REQ*DATA_W  packed payloads; requester k occupies bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have port gnt_o  out  N_REQ  one-hot, one-cycle pulse when the payload of requester k is captured.
REQ-009 SHALL have port data_i  out  DATA_W  payload to the CDC channel.
REQ-010 SHALL have port valid_i  out  1  CDC request level.
REQ-011 SHALL have port valid_o  in  1  CDC acknowledge level, already synchronized into clk_send.
REQ-012 SHALL have port busy_o  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port err_o  out  1  sticky timeout flag.

Function
REQ-014 SHALL implement the FSM states IDLE, SEND and RELEASE, encoded in 2 bits.
REQ-015 In IDLE with any req_i high, SHALL select the lowest index at or after rr_ptr (wrapping modulo N_REQ).
REQ-016 SHALL, in the same cycle, pulse the selected gnt_o bit, register its payload into data_i, set valid_i to 1, and move to SEND.
REQ-017 SHALL update rr_ptr on grant to (granted index + 1) mod N_REQ, and SHALL hold it otherwise.
REQ-018 In SEND, SHALL hold valid_i=1 and data_i constant until valid_o=1 is sampled, then set valid_i=0 and move to RELEASE.
REQ-019 In RELEASE, SHALL hold valid_i=0 until valid_o=0 is sampled, then move to IDLE.
REQ-020 SHALL produce no grant in SEND or RELEASE; requests wait and are not lost.
REQ-021 SHALL allow at most one transfer in flight (four-phase handshake).
REQ-022 SHALL give a minimum spacing of 3 cycles between successive grants (IDLE to SEND to RELEASE to IDLE).
REQ-023 If valid_o is already 1 when in IDLE (stale ack), SHALL not grant until valid_o=0.
REQ-024 SHALL treat a request that drops in the same cycle as its grant as granted.
REQ-025 SHALL use a DATA_W-bit data_i register that is written only on grant.

Reset
REQ-026 On resetn_send=0, SHALL asynchronously set state=IDLE, valid_i=0, data_i=0, gnt_o=0, rr_ptr=0, err_o=0, busy_o=0, and timer=0.
REQ-027 If reset asserts mid-transfer, SHALL abandon the transfer with no gnt_o or valid_i glitch on release.
REQ-028 After reset, SHALL apply REQ-023 before the first grant.

Configuration
REQ-029 With CDC_TX_ARBITER_TIMEOUT_EN defined, SHALL compile in a 16-bit timer that clears on every state entry and increments in SEND and RELEASE.
REQ-030 With CDC_TX_ARBITER_TIMEOUT_EN defined, when the timer reaches TIMEOUT in SEND, SHALL set valid_i=0, set err_o=1 (cleared only by reset), and move to RELEASE.
REQ-031 With CDC_TX_ARBITER_TIMEOUT_EN defined, when the timer reaches TIMEOUT in RELEASE, SHALL set err_o=1 and move to IDLE.
REQ-032 Without CDC_TX_ARBITER_TIMEOUT_EN, SHALL have no timer logic, SHALL tie err_o to 0, and SHALL wait indefinitely for each ack edge.

Verification
REQ-033 SHALL cover a single request: req_i=4'b0100 with payload 8'hA5 -> gnt_o=4'b0100 for one cycle, data_i=8'hA5, valid_i=1 until valid_o=1, then valid_i=0 and busy_o=0 one cycle after valid_o=0.
REQ-034 SHALL cover round robin: req_i=4'b1111 held for 8 transfers -> grant order 0,1,2,3,0,1,2,3 with each payload matching.
REQ-035 SHALL cover fairness with a late requester: req_i=4'b0001, then 4'b1001 raised during SEND -> next grant goes to requester 3, then requester 0.
REQ-036 SHALL cover a stale ack: valid_o=1 at reset release with req_i=4'b0010 -> no grant until valid_o falls, then gnt_o=4'b0010.
REQ-037 SHALL cover timeout with the macro defined and TIMEOUT=16: valid_o held at 0 -> valid_i drops after 16 SEND cycles, err_o=1 and stays 1; without the macro, valid_i stays 1 and err_o=0.
REQ-038 SHALL cover mid-transfer reset: assert resetn_send=0 during SEND -> valid_i=0 and data_i=0 immediately, and rr_ptr restarts at requester 0.
